// File: rtl/blob_tracker.sv
// Purpose : per-frame bounding box, centre and debounced valid flag for NUM_CH colour channels.
// Latency : FE pixel sampled at edge E0, results and frame_done registered at E1.
// Backpres: none; the pixel stream is free-running and every DE cycle is consumed.
//
// Ports: clk/reset (sync, active-high), enable (armed in IDLE only), x_pixel/y_pixel/DE
// video timing, pixel_match per-channel hit flags; outputs are the committed box/centre
// per channel (channel c at [c*W +: W]), pix_count, obj_valid, frame_done, frame_drop, busy.
module blob_tracker #(
   parameter int NUM_CH      = 2,
   parameter int COORD_W     = 10,
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int CNT_W       = 19,
   parameter int MIN_PIXELS  = 64,
   parameter int HOLD_FRAMES = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [COORD_W-1:0]        x_pixel,
   input  logic [COORD_W-1:0]        y_pixel,
   input  logic                      DE,
   input  logic [NUM_CH-1:0]         pixel_match,
   output logic [NUM_CH*COORD_W-1:0] box_xmin,
   output logic [NUM_CH*COORD_W-1:0] box_xmax,
   output logic [NUM_CH*COORD_W-1:0] box_ymin,
   output logic [NUM_CH*COORD_W-1:0] box_ymax,
   output logic [NUM_CH*COORD_W-1:0] center_x,
   output logic [NUM_CH*COORD_W-1:0] center_y,
   output logic [NUM_CH*CNT_W-1:0]   pix_count,
   output logic [NUM_CH-1:0]         obj_valid,
   output logic                      frame_done,
   output logic                      frame_drop,
   output logic                      busy
);

   localparam int                 MISS_W   = $clog2(HOLD_FRAMES + 2);
   localparam logic [MISS_W-1:0]  HOLD_MAX = MISS_W'(HOLD_FRAMES);
   localparam logic [COORD_W:0]   H_LIM    = (COORD_W+1)'(H_ACTIVE);
   localparam logic [COORD_W:0]   V_LIM    = (COORD_W+1)'(V_ACTIVE);
   localparam logic [CNT_W:0]     MIN_P    = (CNT_W+1)'(MIN_PIXELS);

   typedef enum logic [1:0] {IDLE, ACCUM, COMMIT} state_t;
   state_t state;

   logic [COORD_W-1:0] xmin_q [NUM_CH], xmax_q [NUM_CH], ymin_q [NUM_CH], ymax_q [NUM_CH];
   logic [COORD_W-1:0] xmin_d [NUM_CH], xmax_d [NUM_CH], ymin_d [NUM_CH], ymax_d [NUM_CH];
   logic [COORD_W-1:0] ctr_x  [NUM_CH], ctr_y  [NUM_CH];
   logic [CNT_W-1:0]   cnt_q  [NUM_CH], cnt_d  [NUM_CH];
   logic [MISS_W-1:0]  miss_q [NUM_CH];
   logic [NUM_CH-1:0]  hit;

   logic fs, fe, in_rng, start, acc_en;

   assign fs     = DE && (x_pixel == '0) && (y_pixel == '0);
   assign fe     = DE && (x_pixel == COORD_W'(H_ACTIVE-1)) && (y_pixel == COORD_W'(V_ACTIVE-1));
   assign in_rng = ({1'b0, x_pixel} < H_LIM) && ({1'b0, y_pixel} < V_LIM);
   // A frame start either arms tracking from IDLE or restarts a partial frame in ACCUM;
   // in both cases the FS pixel itself is folded into freshly initialised accumulators.
   assign start  = fs && (((state == IDLE) && enable) || (state == ACCUM));
   assign acc_en = start || ((state == ACCUM) && DE && in_rng);
   assign busy   = (state != IDLE);

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         xmin_d[c] = start ? '1 : xmin_q[c];
         xmax_d[c] = start ? '0 : xmax_q[c];
         ymin_d[c] = start ? '1 : ymin_q[c];
         ymax_d[c] = start ? '0 : ymax_q[c];
         cnt_d[c]  = start ? '0 : cnt_q[c];
         if (pixel_match[c]) begin
            if (x_pixel < xmin_d[c]) xmin_d[c] = x_pixel;
            if (x_pixel > xmax_d[c]) xmax_d[c] = x_pixel;
            if (y_pixel < ymin_d[c]) ymin_d[c] = y_pixel;
            if (y_pixel > ymax_d[c]) ymax_d[c] = y_pixel;
            if (cnt_d[c] != '1)      cnt_d[c]  = cnt_d[c] + 1'b1;
         end
         // Sum at COORD_W+1 bits so the midpoint never wraps.
         ctr_x[c] = COORD_W'(({1'b0, xmin_q[c]} + {1'b0, xmax_q[c]}) >> 1);
         ctr_y[c] = COORD_W'(({1'b0, ymin_q[c]} + {1'b0, ymax_q[c]}) >> 1);
         hit[c]   = ({1'b0, cnt_q[c]} >= MIN_P);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         frame_done <= 1'b0;
         frame_drop <= 1'b0;
         box_xmin   <= '0;
         box_xmax   <= '0;
         box_ymin   <= '0;
         box_ymax   <= '0;
         center_x   <= '0;
         center_y   <= '0;
         pix_count  <= '0;
         obj_valid  <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            xmin_q[c] <= '0;
            xmax_q[c] <= '0;
            ymin_q[c] <= '0;
            ymax_q[c] <= '0;
            cnt_q[c]  <= '0;
            miss_q[c] <= '0;
         end
      end else begin
         frame_done <= 1'b0;
         frame_drop <= 1'b0;
         if (acc_en) begin
            for (int c = 0; c < NUM_CH; c++) begin
               xmin_q[c] <= xmin_d[c];
               xmax_q[c] <= xmax_d[c];
               ymin_q[c] <= ymin_d[c];
               ymax_q[c] <= ymax_d[c];
               cnt_q[c]  <= cnt_d[c];
            end
         end
         case (state)
            IDLE: begin
               if (fs && enable) state <= ACCUM;
            end
            ACCUM: begin
               // Restart wins: a new FS means the previous frame was truncated.
               if (fs)      frame_drop <= 1'b1;
               else if (fe) state      <= COMMIT;
            end
            COMMIT: begin
               state      <= IDLE;
               frame_done <= 1'b1;
               for (int c = 0; c < NUM_CH; c++) begin
                  pix_count[c*CNT_W +: CNT_W] <= cnt_q[c];
                  if (hit[c]) begin
                     box_xmin[c*COORD_W +: COORD_W] <= xmin_q[c];
                     box_xmax[c*COORD_W +: COORD_W] <= xmax_q[c];
                     box_ymin[c*COORD_W +: COORD_W] <= ymin_q[c];
                     box_ymax[c*COORD_W +: COORD_W] <= ymax_q[c];
                     center_x[c*COORD_W +: COORD_W] <= ctr_x[c];
                     center_y[c*COORD_W +: COORD_W] <= ctr_y[c];
                     obj_valid[c] <= 1'b1;
                     miss_q[c]    <= '0;
                  end else if (miss_q[c] < HOLD_MAX) begin
                     miss_q[c] <= miss_q[c] + 1'b1;
                  end else begin
                     // Box and centre stay stale; obj_valid qualifies them.
                     obj_valid[c] <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_blob_tracker.sv
// Purpose : self-checking bench for blob_tracker with a scoreboard of per-frame expectations.
// Latency : expected results are pushed at FE and popped when frame_done is seen.
// Backpres: n/a; the bench drives a free-running pixel stream with blanking.
module tb_blob_tracker;

   localparam int NC = 2, CW = 10, HA = 16, VA = 8, NW = 4, MINP = 4, HOLD = 2;

   logic clk = 1'b0, reset = 1'b1, enable = 1'b1, DE = 1'b0;
   logic [CW-1:0]    x_pixel = '0, y_pixel = '0;
   logic [NC-1:0]    pixel_match = '0;
   logic [NC*CW-1:0] box_xmin, box_xmax, box_ymin, box_ymax, center_x, center_y;
   logic [NC*NW-1:0] pix_count;
   logic [NC-1:0]    obj_valid;
   logic             frame_done, frame_drop, busy;

   always #5 clk = ~clk;

   blob_tracker #(.NUM_CH(NC), .COORD_W(CW), .H_ACTIVE(HA), .V_ACTIVE(VA), .CNT_W(NW),
                  .MIN_PIXELS(MINP), .HOLD_FRAMES(HOLD)) dut (
      .clk(clk), .reset(reset), .enable(enable), .x_pixel(x_pixel), .y_pixel(y_pixel),
      .DE(DE), .pixel_match(pixel_match), .box_xmin(box_xmin), .box_xmax(box_xmax),
      .box_ymin(box_ymin), .box_ymax(box_ymax), .center_x(center_x), .center_y(center_y),
      .pix_count(pix_count), .obj_valid(obj_valid), .frame_done(frame_done),
      .frame_drop(frame_drop), .busy(busy));

   typedef struct packed {
      logic [NC*CW-1:0] xmin, xmax, ymin, ymax, cx, cy;
      logic [NC*NW-1:0] cnt;
      logic [NC-1:0]    valid;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0, n_fail = 0, done_cnt = 0, drop_cnt = 0;
   bit   busy_seen = 0;

   // reference model: committed state and running accumulators
   logic [NC*CW-1:0] m_xmin = '0, m_xmax = '0, m_ymin = '0, m_ymax = '0, m_cx = '0, m_cy = '0;
   logic [NC-1:0]    m_valid = '0;
   int m_miss[NC], a_xmin[NC], a_xmax[NC], a_ymin[NC], a_ymax[NC], a_cnt[NC];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] pat(input int pid, input int x, input int y);
      logic m0, m1;
      m0 = 1'b0; m1 = 1'b0;
      case (pid)
         0: m0 = (x >= 3 && x <= 6 && y >= 2 && y <= 4);
         1: begin m0 = (x >= 3 && x <= 6 && y >= 2 && y <= 4); m1 = (x >= 10 && y == 7); end
         2: m0 = (y == 5 && x >= 8 && x <= 10);
         4: m0 = (y == 1) || (y == 2 && x <= 3);
         5: begin m0 = 1'b1; m1 = 1'b1; end
         default: ;
      endcase
      return {m1, m0};
   endfunction

   task automatic drive(input int x, input int y, input logic de, input logic [1:0] m);
      @(negedge clk);
      x_pixel = CW'(x); y_pixel = CW'(y); DE = de; pixel_match = m;
   endtask

   task automatic acc_init();
      for (int c = 0; c < NC; c++) begin
         a_xmin[c] = 1023; a_xmax[c] = 0; a_ymin[c] = 1023; a_ymax[c] = 0; a_cnt[c] = 0;
      end
   endtask

   task automatic acc_pix(input int x, input int y, input logic [1:0] m);
      for (int c = 0; c < NC; c++) if (m[c]) begin
         if (x < a_xmin[c]) a_xmin[c] = x;
         if (x > a_xmax[c]) a_xmax[c] = x;
         if (y < a_ymin[c]) a_ymin[c] = y;
         if (y > a_ymax[c]) a_ymax[c] = y;
         if (a_cnt[c] < 15) a_cnt[c]++;
      end
   endtask

   task automatic model_commit();
      exp_t e;
      for (int c = 0; c < NC; c++) begin
         e.cnt[c*NW +: NW] = NW'(a_cnt[c]);
         if (a_cnt[c] >= MINP) begin
            m_xmin[c*CW +: CW] = CW'(a_xmin[c]);
            m_xmax[c*CW +: CW] = CW'(a_xmax[c]);
            m_ymin[c*CW +: CW] = CW'(a_ymin[c]);
            m_ymax[c*CW +: CW] = CW'(a_ymax[c]);
            m_cx[c*CW +: CW]   = CW'((a_xmin[c] + a_xmax[c]) / 2);
            m_cy[c*CW +: CW]   = CW'((a_ymin[c] + a_ymax[c]) / 2);
            m_valid[c] = 1'b1;
            m_miss[c]  = 0;
         end else if (m_miss[c] < HOLD) begin
            m_miss[c]++;
         end else begin
            m_valid[c] = 1'b0;
         end
      end
      e.xmin = m_xmin; e.xmax = m_xmax; e.ymin = m_ymin; e.ymax = m_ymax;
      e.cx = m_cx; e.cy = m_cy; e.valid = m_valid;
      q.push_back(e);
   endtask

   // Full frame with line blanking (one out-of-range DE pixel per line) and vertical blanking.
   task automatic run_frame(input int pid, input bit commit, input int en_drop_row);
      logic [1:0] m;
      acc_init();
      for (int y = 0; y < VA; y++) begin
         if (y == en_drop_row) enable = 1'b0;
         for (int x = 0; x < HA; x++) begin
            m = pat(pid, x, y);
            drive(x, y, 1'b1, m);
            acc_pix(x, y, m);
         end
         drive(HA, y, 1'b1, 2'b11);
         drive(HA + 1, y, 1'b0, 2'b11);
      end
      if (commit) model_commit();
      drive(0, VA, 1'b1, 2'b11);
      for (int i = 0; i < 3; i++) drive(0, VA + 1, 1'b0, 2'b00);
      if (commit) begin
         for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
         chk("commit_seen", q.size(), 0);
         q.delete();
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_xmin"}, box_xmin, 0);  chk({tag, "_xmax"}, box_xmax, 0);
      chk({tag, "_ymin"}, box_ymin, 0);  chk({tag, "_ymax"}, box_ymax, 0);
      chk({tag, "_cx"}, center_x, 0);    chk({tag, "_cy"}, center_y, 0);
      chk({tag, "_cnt"}, pix_count, 0);  chk({tag, "_valid"}, obj_valid, 0);
      chk({tag, "_done"}, frame_done, 0); chk({tag, "_drop"}, frame_drop, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   // Output monitor: pops the scoreboard on every frame_done.
   always @(negedge clk) begin
      exp_t e;
      if (busy) busy_seen = 1'b1;
      if (frame_drop) drop_cnt++;
      if (frame_done) begin
         done_cnt++;
         if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            e = q.pop_front();
            chk("box_xmin", box_xmin, e.xmin); chk("box_xmax", box_xmax, e.xmax);
            chk("box_ymin", box_ymin, e.ymin); chk("box_ymax", box_ymax, e.ymax);
            chk("center_x", center_x, e.cx);   chk("center_y", center_y, e.cy);
            chk("pix_count", pix_count, e.cnt); chk("obj_valid", obj_valid, e.valid);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int d0, n0;
      for (int c = 0; c < NC; c++) m_miss[c] = 0;
      acc_init();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_zero("rst");

      // single blob, then two channels together
      run_frame(0, 1'b1, -1);
      run_frame(1, 1'b1, -1);

      // hysteresis: three frames below threshold on both channels
      for (int i = 0; i < 3; i++) run_frame(2, 1'b1, -1);
      run_frame(0, 1'b1, -1);

      // partial frame: FS plus 19 more DE pixels, then a new FS starts a full frame
      d0 = drop_cnt; n0 = done_cnt;
      for (int i = 0; i < 20; i++) drive(i % HA, i / HA, 1'b1, 2'b11);
      chk("busy_partial", busy, 1);
      run_frame(0, 1'b1, -1);
      chk("drop_pulses", drop_cnt - d0, 1);
      chk("done_after_partial", done_cnt - n0, 1);

      // reset in the middle of a frame at pixel (5,3)
      n0 = done_cnt;
      for (int i = 0; i < HA * 3 + 5; i++) drive(i % HA, i / HA, 1'b1, pat(1, i % HA, i / HA));
      @(negedge clk);
      x_pixel = 5; y_pixel = 3; DE = 1'b1; pixel_match = pat(1, 5, 3); reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; DE = 1'b0; pixel_match = '0;
      check_zero("midrst");
      m_xmin = '0; m_xmax = '0; m_ymin = '0; m_ymax = '0; m_cx = '0; m_cy = '0; m_valid = '0;
      for (int c = 0; c < NC; c++) m_miss[c] = 0;
      repeat (3) @(negedge clk);
      chk("no_done_after_rst", done_cnt - n0, 0);
      run_frame(0, 1'b1, -1);

      // enable dropped mid-frame still commits; saturating count on 20 matches
      run_frame(4, 1'b1, 4);

      // enable low at FS: no tracking at all
      n0 = done_cnt; busy_seen = 1'b0;
      run_frame(0, 1'b0, -1);
      chk("no_done_disabled", done_cnt - n0, 0);
      chk("no_busy_disabled", busy_seen, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
